// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier: state encoding and width.
// State codes are exported on state_o for debug, so they are fixed.
package mult_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_TEST  = 3'b010,
    S_ADD   = 3'b011,
    S_SHIFT = 3'b100,
    S_ALIGN = 3'b101,
    S_DONE  = 3'b110
  } state_t;

endpackage

// File: rtl/shift_add_mult_dp.sv
// Datapath of the shift-add multiplier: operand capture, accumulator R,
// iteration count and product register. Driven by one-hot op strobes.
// Ports: clk, rst (async active-low); capture/load/add/shift/align/
// publish strobes; a, b operands; r0, m_zero, cnt_zero flags; product.
module shift_add_mult_dp
  import mult_pkg::*;
#(
  parameter int WA = 8,
  parameter int WB = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             load,
  input  logic             add,
  input  logic             shift,
  input  logic             align,
  input  logic             publish,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic             r0,
  output logic             m_zero,
  output logic             cnt_zero,
  output logic [WA+WB-1:0] product
);

  localparam int RW = WA + WB + 1;
  localparam int CW = $clog2(WB + 1);

  logic [WA-1:0] a_q, a_q_n;
  logic [WB-1:0] m, m_n;
  logic [RW-1:0] r, r_n;
  logic [CW-1:0] cnt, cnt_n;

  always_comb begin
    a_q_n = a_q;
    m_n   = m;
    r_n   = r;
    cnt_n = cnt;
    if (capture) begin
      a_q_n = a;
      m_n   = b;
    end
    if (load) begin
      // m holds b as captured, immune to later bus changes
      r_n   = {{(WA+1){1'b0}}, m};
      cnt_n = CW'(WB);
    end
    if (add) begin
      // upper field is WA+1 wide so the carry stays in R
      r_n[RW-1:WB] = r[RW-1:WB] + {1'b0, a_q};
    end
    if (shift) begin
      r_n   = r >> 1;
      m_n   = m >> 1;
      cnt_n = cnt - CW'(1);
    end
    if (align) begin
      // skip the remaining all-zero multiplier bits in one step
      r_n   = r >> cnt;
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      m       <= '0;
      r       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      a_q <= a_q_n;
      m   <= m_n;
      r   <= r_n;
      cnt <= cnt_n;
      // capture the post-update R so product is valid in DONE
      if (publish) product <= r_n[WA+WB-1:0];
    end
  end

  assign r0     = r[0];
  assign m_zero = (m == '0);
  // reflects the count after this cycle's update (SHIFT decides on it)
  assign cnt_zero = (cnt_n == '0);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add unsigned multiplier, start/busy/done handshake.
// Ports: clk, rst (async active-low), start, a[WA], b[WB] in; busy, done,
// product[WA+WB], state_o[3] out. Macro MULT_EARLY_EXIT_EN: early exit.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WA = 8,
  parameter int WB = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WA-1:0]      a,
  input  logic [WB-1:0]      b,
  output logic               busy,
  output logic               done,
  output logic [WA+WB-1:0]   product,
  output logic [STATE_W-1:0] state_o
);

  state_t state, state_n;

  logic capture;
  logic load;
  logic add;
  logic shift;
  logic align;
  logic publish;
  logic r0;
  logic m_zero;
  logic cnt_zero;

  shift_add_mult_dp #(
    .WA(WA),
    .WB(WB)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .load     (load),
    .add      (add),
    .shift    (shift),
    .align    (align),
    .publish  (publish),
    .a        (a),
    .b        (b),
    .r0       (r0),
    .m_zero   (m_zero),
    .cnt_zero (cnt_zero),
    .product  (product)
  );

`ifndef MULT_EARLY_EXIT_EN
  logic unused_m_zero;
  assign unused_m_zero = m_zero;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = S_IDLE;
    capture = 1'b0;
    load    = 1'b0;
    add     = 1'b0;
    shift   = 1'b0;
    align   = 1'b0;
    publish = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_n = S_LOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_n = S_TEST;
      end
      S_TEST: begin
`ifdef MULT_EARLY_EXIT_EN
        if (m_zero)  state_n = S_ALIGN;
        else if (r0) state_n = S_ADD;
        else         state_n = S_SHIFT;
`else
        if (r0) state_n = S_ADD;
        else    state_n = S_SHIFT;
`endif
      end
      S_ADD: begin
        add     = 1'b1;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (cnt_zero) begin
          publish = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_TEST;
        end
      end
      S_ALIGN: begin
        align   = 1'b1;
        publish = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign state_o = state;

endmodule
